// File: rtl/edc_pkg.sv
// Shared constants and types for the read-side EDC path: data/check widths,
// the per-data-bit syndrome columns and the syndrome classification.
package edc_pkg;

    localparam int DATA_W  = 32;
    localparam int CHECK_W = 8;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        CLEAN     = 2'd0,
        SEC_DATA  = 2'd1,
        SEC_CHECK = 2'd2,
        DED       = 2'd3
    } edc_class_e;

    // Column of data bit i, highest bit first. Bits 0..15 hit one of S[3:0] plus
    // one of S[5:4] and one of S[7:6]; bits 16..31 hit one of S[7:4] plus one of
    // S[1:0] and one of S[3:2], so every column is unique with weight 3.
    localparam logic [DATA_W-1:0][CHECK_W-1:0] DATA_COL = {
        8'h8A, 8'h4A, 8'h2A, 8'h1A,
        8'h86, 8'h46, 8'h26, 8'h16,
        8'h89, 8'h49, 8'h29, 8'h19,
        8'h85, 8'h45, 8'h25, 8'h15,
        8'hA8, 8'hA4, 8'hA2, 8'hA1,
        8'h68, 8'h64, 8'h62, 8'h61,
        8'h98, 8'h94, 8'h92, 8'h91,
        8'h58, 8'h54, 8'h52, 8'h51
    };

endpackage

// File: rtl/edc_syndrome_decode.sv
// Maps a syndrome to its error class and the index of the bit to flip
// (data bit index for SEC_DATA, check bit index for SEC_CHECK).
module edc_syndrome_decode
    import edc_pkg::*;
(
    input  logic [CHECK_W-1:0] syn_i,
    output logic [1:0]         cls_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [DATA_W-1:0] col_hit;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_hit
            assign col_hit[gi] = (syn_i == DATA_COL[gi]);
        end
    endgenerate

    always_comb begin
        cls_o = DED;
        idx_o = '0;
        if (syn_i == '0) begin
            cls_o = CLEAN;
        end else if (|col_hit) begin
            cls_o = SEC_DATA;
            for (int k = 0; k < DATA_W; k++) begin
                if (col_hit[k]) idx_o = IDX_W'(k);
            end
        end else if ($countones(syn_i) == 1) begin
            cls_o = SEC_CHECK;
            for (int k = 0; k < CHECK_W; k++) begin
                if (syn_i[k]) idx_o = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/edcg_mod.sv
// EDC check-bit generator. With r_i=0 it produces the check code of data_i;
// with r_i=1 it folds in the stored check bits and so yields the syndrome.
module edcg_mod
    import edc_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [CHECK_W-1:0] check_i,
    input  logic               r_i,
    output logic [CHECK_W-1:0] code_o
);

    logic [DATA_W-1:0][CHECK_W-1:0] term;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_term
            assign term[gi] = data_i[gi] ? DATA_COL[gi] : '0;
        end
    endgenerate

    always_comb begin
        code_o = r_i ? check_i : '0;
        for (int k = 0; k < DATA_W; k++) begin
            code_o = code_o ^ term[k];
        end
    end

endmodule

// File: rtl/edc_corrector.sv
// Read-side SEC/DED corrector: two-stage elastic pipeline (syndrome, then
// correction) with saturating event counters and a first-error log.
module edc_corrector
    import edc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_data,
    input  logic [7:0]        i_check,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_data,
    output logic [7:0]        o_check,
    output logic [7:0]        o_syndrome,
    output logic              o_sec,
    output logic              o_ded,
    input  logic              i_clr,
    output logic [CNT_W-1:0]  o_sec_cnt,
    output logic [CNT_W-1:0]  o_ded_cnt,
    output logic              o_log_valid,
    output logic              o_log_ded,
    output logic [ADDR_W-1:0] o_log_addr
);

    logic               s1_valid_q;
    logic [31:0]        s1_data_q;
    logic [7:0]         s1_check_q;
    logic [7:0]         s1_syn_q;
    logic [ADDR_W-1:0]  s1_addr_q;

    logic               s2_valid_q;
    logic [31:0]        s2_data_q;
    logic [7:0]         s2_check_q;
    logic [7:0]         s2_syn_q;
    logic               s2_sec_q;
    logic               s2_ded_q;
    logic [ADDR_W-1:0]  s2_addr_q;

    logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]   ded_cnt_q, ded_cnt_d;
    logic               log_valid_q, log_valid_d;
    logic               log_ded_q, log_ded_d;
    logic [ADDR_W-1:0]  log_addr_q, log_addr_d;

    logic               s1_load, s2_load, out_fire;
    logic [7:0]         in_syn;
    logic [1:0]         dec_cls;
    logic [IDX_W-1:0]   dec_idx;
    logic [31:0]        corr_data;
    logic [7:0]         corr_check;

    assign s2_load  = ~s2_valid_q | i_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign out_fire = s2_valid_q & i_ready;
    assign o_ready  = s1_load;

    edcg_mod u_gen (
        .data_i  (i_data),
        .check_i (i_check),
        .r_i     (1'b1),
        .code_o  (in_syn)
    );

    edc_syndrome_decode u_dec (
        .syn_i (s1_syn_q),
        .cls_o (dec_cls),
        .idx_o (dec_idx)
    );

    // DED words pass through raw; only a matched column or single check bit flips.
    always_comb begin
        corr_data  = s1_data_q;
        corr_check = s1_check_q;
        if (dec_cls == SEC_DATA) begin
            corr_data[dec_idx] = ~s1_data_q[dec_idx];
        end
        if (dec_cls == SEC_CHECK) begin
            corr_check[dec_idx[2:0]] = ~s1_check_q[dec_idx[2:0]];
        end
    end

    // Clear is applied first so an event transferring alongside it still counts.
    always_comb begin
        sec_cnt_d   = i_clr ? '0 : sec_cnt_q;
        ded_cnt_d   = i_clr ? '0 : ded_cnt_q;
        log_valid_d = i_clr ? 1'b0 : log_valid_q;
        log_ded_d   = i_clr ? 1'b0 : log_ded_q;
        log_addr_d  = i_clr ? '0 : log_addr_q;
        if (out_fire && s2_sec_q && (sec_cnt_d != '1)) begin
            sec_cnt_d = sec_cnt_d + CNT_W'(1);
        end
        if (out_fire && s2_ded_q && (ded_cnt_d != '1)) begin
            ded_cnt_d = ded_cnt_d + CNT_W'(1);
        end
        if (out_fire && (s2_sec_q || s2_ded_q) &&
            (!log_valid_d || (s2_ded_q && !log_ded_d))) begin
            log_valid_d = 1'b1;
            log_ded_d   = s2_ded_q;
            log_addr_d  = s2_addr_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_check_q  <= '0;
            s1_syn_q    <= '0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_check_q  <= '0;
            s2_syn_q    <= '0;
            s2_sec_q    <= 1'b0;
            s2_ded_q    <= 1'b0;
            s2_addr_q   <= '0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
            log_valid_q <= 1'b0;
            log_ded_q   <= 1'b0;
            log_addr_q  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= i_valid;
                if (i_valid) begin
                    s1_data_q  <= i_data;
                    s1_check_q <= i_check;
                    s1_syn_q   <= in_syn;
                    s1_addr_q  <= i_addr;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                s2_sec_q   <= s1_valid_q & ((dec_cls == SEC_DATA) | (dec_cls == SEC_CHECK));
                s2_ded_q   <= s1_valid_q & (dec_cls == DED);
                if (s1_valid_q) begin
                    s2_data_q  <= corr_data;
                    s2_check_q <= corr_check;
                    s2_syn_q   <= s1_syn_q;
                    s2_addr_q  <= s1_addr_q;
                end
            end
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
            log_valid_q <= log_valid_d;
            log_ded_q   <= log_ded_d;
            log_addr_q  <= log_addr_d;
        end
    end

    assign o_valid     = s2_valid_q;
    assign o_data      = s2_data_q;
    assign o_check     = s2_check_q;
    assign o_syndrome  = s2_syn_q;
    assign o_sec       = s2_sec_q;
    assign o_ded       = s2_ded_q;
    assign o_sec_cnt   = sec_cnt_q;
    assign o_ded_cnt   = ded_cnt_q;
    assign o_log_valid = log_valid_q;
    assign o_log_ded   = log_ded_q;
    assign o_log_addr  = log_addr_q;

endmodule

// File: tb/tb_edc_corrector.sv
// Randomized and directed bench for edc_corrector against a syndrome model
// built directly from the column rules; a second instance uses 2-bit counters.
module tb_edc_corrector;

    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  check;
        logic [7:0]  syn;
        logic        sec;
        logic        ded;
        logic [31:0] addr;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b0;
    logic i_clr = 1'b0;
    logic [31:0] i_data = '0;
    logic [7:0]  i_check = '0;
    logic [ADDR_W-1:0] i_addr = '0;

    logic a_ready, a_valid, a_sec, a_ded, a_log_valid, a_log_ded;
    logic [31:0] a_data, a_log_addr;
    logic [7:0]  a_check, a_syn;
    logic [15:0] a_sec_cnt, a_ded_cnt;

    logic b_ready, b_valid, b_sec, b_ded, b_log_valid, b_log_ded;
    logic [31:0] b_data, b_log_addr;
    logic [7:0]  b_check, b_syn;
    logic [1:0]  b_sec_cnt, b_ded_cnt;

    always #5 clk = ~clk;

    edc_corrector #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(a_ready),
        .i_data(i_data), .i_check(i_check), .i_addr(i_addr), .o_valid(a_valid),
        .i_ready(i_ready), .o_data(a_data), .o_check(a_check), .o_syndrome(a_syn),
        .o_sec(a_sec), .o_ded(a_ded), .i_clr(i_clr), .o_sec_cnt(a_sec_cnt),
        .o_ded_cnt(a_ded_cnt), .o_log_valid(a_log_valid), .o_log_ded(a_log_ded),
        .o_log_addr(a_log_addr)
    );

    edc_corrector #(.ADDR_W(ADDR_W), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(b_ready),
        .i_data(i_data), .i_check(i_check), .i_addr(i_addr), .o_valid(b_valid),
        .i_ready(i_ready), .o_data(b_data), .o_check(b_check), .o_syndrome(b_syn),
        .o_sec(b_sec), .o_ded(b_ded), .i_clr(i_clr), .o_sec_cnt(b_sec_cnt),
        .o_ded_cnt(b_ded_cnt), .o_log_valid(b_log_valid), .o_log_ded(b_log_ded),
        .o_log_addr(b_log_addr)
    );

    int n_vec = 0;
    int n_err = 0;
    word_t exp_q[$];
    logic [15:0] m_sec, m_ded;
    logic [1:0]  m_sec2, m_ded2;
    logic        m_lv, m_ld;
    logic [31:0] m_la;
    bit          fired, in_acc;
    logic [49:0] got, want;

    // Syndrome column of data bit i, straight from the generator's equations.
    function automatic logic [7:0] col_of(input int i);
        int n;
        int p;
        logic [7:0] c;
        n = (i % 16) / 4;
        p = i % 4;
        c = '0;
        if (i < 16) begin
            c[p] = 1'b1; c[4 + n / 2] = 1'b1; c[6 + n % 2] = 1'b1;
        end else begin
            c[4 + p] = 1'b1; c[n / 2] = 1'b1; c[2 + n % 2] = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [7:0] gen_check(input logic [31:0] d);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) if (d[i]) c = c ^ col_of(i);
        return c;
    endfunction

    function automatic word_t predict(input logic [31:0] d, input logic [7:0] c, input logic [31:0] a);
        word_t w;
        logic [7:0] s;
        int hit;
        s = gen_check(d) ^ c;
        w.data = d; w.check = c; w.syn = s; w.sec = 1'b0; w.ded = 1'b0; w.addr = a;
        hit = -1;
        for (int i = 0; i < 32; i++) if (col_of(i) == s) hit = i;
        if (s != 8'h00) begin
            if (hit >= 0) begin
                w.data[hit] = ~w.data[hit]; w.sec = 1'b1;
            end else if ($countones(s) == 1) begin
                w.check = c ^ s; w.sec = 1'b1;
            end else begin
                w.ded = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [49:0] obs_of(input word_t w);
        return {w.data, w.check, w.syn, w.sec, w.ded};
    endfunction

    task automatic model_clear();
        m_sec = '0; m_ded = '0; m_sec2 = '0; m_ded2 = '0;
        m_lv = 1'b0; m_ld = 1'b0; m_la = '0;
    endtask

    // Advance one cycle: sample handshakes at the falling edge, update the model.
    task automatic tick();
        word_t w;
        @(negedge clk);
        in_acc = i_valid && a_ready;
        fired  = a_valid && i_ready;
        if (i_clr) model_clear();
        if (fired) begin
            got = {a_data, a_check, a_syn, a_sec, a_ded};
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                want = obs_of(w);
                if (w.sec) begin
                    if (m_sec != 16'hFFFF) m_sec = m_sec + 16'd1;
                    if (m_sec2 != 2'b11) m_sec2 = m_sec2 + 2'd1;
                end
                if (w.ded) begin
                    if (m_ded != 16'hFFFF) m_ded = m_ded + 16'd1;
                    if (m_ded2 != 2'b11) m_ded2 = m_ded2 + 2'd1;
                end
                if ((w.sec || w.ded) && (!m_lv || (w.ded && !m_ld))) begin
                    m_lv = 1'b1; m_ld = w.ded; m_la = w.addr;
                end
            end else begin
                want = 'x;
            end
        end
        if (in_acc) exp_q.push_back(predict(i_data, i_check, i_addr));
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [7:0] c, input logic [31:0] a, output bit ok);
        i_ready = 1'b1; i_valid = 1'b1; i_data = d; i_check = c; i_addr = a;
        tick();
        i_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 8 && !ok; t++) begin
            tick();
            ok = fired;
        end
    endtask

    task automatic test_reset();
        logic [117:0] ra;
        logic [89:0]  rb;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ra = {a_ready, a_valid, a_data, a_check, a_syn, a_sec, a_ded, a_sec_cnt, a_ded_cnt, a_log_valid, a_log_ded, a_log_addr};
        rb = {b_ready, b_valid, b_data, b_check, b_syn, b_sec, b_ded, b_sec_cnt, b_ded_cnt, b_log_valid, b_log_ded, b_log_addr};
        n_vec++;
        if (ra !== {1'b1, 117'd0}) begin
            n_err++; $display("FAIL reset_state: got %h want %h", ra, {1'b1, 117'd0});
        end
        n_vec++;
        if (rb !== {1'b1, 89'd0}) begin
            n_err++; $display("FAIL reset_state_sat: got %h want %h", rb, {1'b1, 89'd0});
        end
        exp_q.delete();
        model_clear();
        rst_n = 1'b1;
        $display("reset: outputs cleared, o_ready=%0b", a_ready);
    endtask

    task automatic test_directed();
        logic [31:0] dm [6];
        logic [7:0]  cm [6];
        logic [31:0] am [6];
        logic [7:0]  sm [6];
        logic [5:0]  secm, dedm;
        logic [31:0] d, ed;
        logic [7:0]  c, ec;
        bit ok;
        dm = '{32'h0, 32'h1, 32'h0001_0000, 32'h8000_0000, 32'h0, 32'h3};
        cm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
        am = '{32'h0, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h200};
        sm = '{8'h00, 8'h51, 8'h15, 8'h8A, 8'h20, 8'h03};
        secm = 6'b011110;
        dedm = 6'b100000;
        d = 32'h1234_5678;
        c = gen_check(d);
        for (int k = 0; k < 6; k++) begin
            send_word(d ^ dm[k], c ^ cm[k], am[k], ok);
            ed = dedm[k] ? (d ^ dm[k]) : d;
            ec = dedm[k] ? (c ^ cm[k]) : c;
            n_vec++;
            if (!ok) begin
                n_err++; $display("FAIL directed_timeout[%0d]: o_valid never rose, want 1", k);
            end else begin
                n_vec++;
                if (got !== want) begin
                    n_err++; $display("FAIL directed_model[%0d]: got %h want %h", k, got, want);
                end
                n_vec++;
                if (got !== {ed, ec, sm[k], secm[k], dedm[k]}) begin
                    n_err++; $display("FAIL directed_const[%0d]: got %h want %h", k, got, {ed, ec, sm[k], secm[k], dedm[k]});
                end
            end
            n_vec++;
            if ({a_sec_cnt, a_ded_cnt, b_sec_cnt, b_ded_cnt, a_log_valid, a_log_ded, a_log_addr} !== {m_sec, m_ded, m_sec2, m_ded2, m_lv, m_ld, m_la}) begin
                n_err++; $display("FAIL directed_counters[%0d]: got %h want %h", k,
                    {a_sec_cnt, a_ded_cnt, b_sec_cnt, b_ded_cnt, a_log_valid, a_log_ded, a_log_addr}, {m_sec, m_ded, m_sec2, m_ded2, m_lv, m_ld, m_la});
            end
            if (k == 1) begin
                n_vec++;
                if ({a_sec_cnt, a_log_valid, a_log_ded, a_log_addr} !== {16'd1, 1'b1, 1'b0, 32'h100}) begin
                    n_err++; $display("FAIL first_sec_log: got %h want %h", {a_sec_cnt, a_log_valid, a_log_ded, a_log_addr}, {16'd1, 1'b1, 1'b0, 32'h100});
                end
            end
            $display("directed[%0d]: data=%h syn=%h sec=%0b ded=%0b", k, got[49:18], got[9:2], got[1], got[0]);
        end
        n_vec++;
        if ({a_sec_cnt, a_ded_cnt, a_log_valid, a_log_ded, a_log_addr} !== {16'd4, 16'd1, 1'b1, 1'b1, 32'h200}) begin
            n_err++; $display("FAIL ded_log_upgrade: got %h want %h", {a_sec_cnt, a_ded_cnt, a_log_valid, a_log_ded, a_log_addr}, {16'd4, 16'd1, 1'b1, 1'b1, 32'h200});
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] wd [4];
        logic [7:0]  wc [4];
        int acc, outs, b;
        logic [15:0] sec_before;
        for (int k = 0; k < 4; k++) begin
            wd[k] = $urandom;
            wc[k] = gen_check(wd[k]);
            b = int'($urandom_range(31, 0));
            wd[k][b] = ~wd[k][b];
        end
        sec_before = m_sec;
        acc = 0;
        outs = 0;
        i_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            i_valid = (acc < 4); i_data = wd[acc % 4]; i_check = wc[acc % 4]; i_addr = 32'h500 + 32'(acc);
            tick();
            if (in_acc) acc++;
            if (a_valid && exp_q.size() != 0) begin
                n_vec++;
                if ({a_data, a_check, a_syn, a_sec, a_ded} !== obs_of(exp_q[0])) begin
                    n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", t, {a_data, a_check, a_syn, a_sec, a_ded}, obs_of(exp_q[0]));
                end
            end
        end
        n_vec++;
        if (acc != 2 || a_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_accept: accepted %0d o_ready %b, want 2 and 0", acc, a_ready);
        end
        i_ready = 1'b1;
        for (int t = 0; t < 20 && outs < 4; t++) begin
            i_valid = (acc < 4); i_data = wd[acc % 4]; i_check = wc[acc % 4]; i_addr = 32'h500 + 32'(acc);
            tick();
            if (in_acc) acc++;
            if (fired) begin
                outs++;
                n_vec++;
                if (got !== want) begin
                    n_err++; $display("FAIL stall_order[%0d]: got %h want %h", outs, got, want);
                end
                $display("stall release: word %0d data=%h sec=%0b", outs, got[49:18], got[1]);
            end
        end
        i_valid = 1'b0;
        n_vec++;
        if (outs != 4) begin
            n_err++; $display("FAIL stall_drain: got %0d words want 4", outs);
        end
        n_vec++;
        if (a_sec_cnt !== sec_before + 16'd4) begin
            n_err++; $display("FAIL stall_count_once: got %0d want %0d", a_sec_cnt, sec_before + 16'd4);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0]  c;
        logic [39:0] cw;
        int kind, p0, p1;
        for (int t = 0; t < 400; t++) begin
            d = $urandom;
            c = gen_check(d);
            kind = int'($urandom_range(3, 0));
            if (kind == 1) begin
                p0 = int'($urandom_range(31, 0)); d[p0] = ~d[p0];
            end else if (kind == 2) begin
                p0 = int'($urandom_range(7, 0)); c[p0] = ~c[p0];
            end else if (kind == 3) begin
                p0 = int'($urandom_range(39, 0));
                p1 = (p0 + 1 + int'($urandom_range(38, 0))) % 40;
                cw = {c, d}; cw[p0] = ~cw[p0]; cw[p1] = ~cw[p1]; {c, d} = cw;
            end
            i_data = d; i_check = c; i_addr = $urandom;
            i_valid = ($urandom_range(3, 0) != 0);
            i_ready = ($urandom_range(3, 0) != 0);
            i_clr   = ($urandom_range(39, 0) == 0);
            tick();
            if (fired) begin
                n_vec++;
                if (got !== want) begin
                    n_err++; $display("FAIL random_word[%0d]: got %h want %h", t, got, want);
                end
                n_vec++;
                if (got[1] && got[0]) begin
                    n_err++; $display("FAIL random_sec_ded_both[%0d]: got sec=1 ded=1 want at most one", t);
                end
            end
            n_vec++;
            if ({a_sec_cnt, a_ded_cnt, b_sec_cnt, b_ded_cnt, a_log_valid, a_log_ded, a_log_addr} !== {m_sec, m_ded, m_sec2, m_ded2, m_lv, m_ld, m_la}) begin
                n_err++; $display("FAIL random_counters[%0d]: got %h want %h", t,
                    {a_sec_cnt, a_ded_cnt, b_sec_cnt, b_ded_cnt, a_log_valid, a_log_ded, a_log_addr}, {m_sec, m_ded, m_sec2, m_ded2, m_lv, m_ld, m_la});
            end
        end
        i_valid = 1'b0; i_clr = 1'b0; i_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (fired) begin
                n_vec++;
                if (got !== want) begin
                    n_err++; $display("FAIL random_drain_word: got %h want %h", got, want);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0 || a_valid !== 1'b0) begin
            n_err++; $display("FAIL random_drain: pending %0d o_valid %b, want 0 and 0", exp_q.size(), a_valid);
        end
        $display("random: %0d sec, %0d ded counted", m_sec, m_ded);
    endtask

    task automatic test_saturate_clear();
        logic [31:0] d;
        logic [7:0]  c;
        bit ok;
        i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = $urandom; c = gen_check(d); d[k] = ~d[k];
            send_word(d, c, 32'h300 + 32'(k), ok);
            n_vec++;
            if (!ok || got !== want) begin
                n_err++; $display("FAIL sat_word[%0d]: got %h want %h", k, got, want);
            end
        end
        n_vec++;
        if ({a_sec_cnt, b_sec_cnt} !== {16'd5, 2'd3}) begin
            n_err++; $display("FAIL sec_saturate: got %0d/%0d want 5/3", a_sec_cnt, b_sec_cnt);
        end
        $display("saturate: sec_cnt=%0d sat_cnt=%0d", a_sec_cnt, b_sec_cnt);
        d = $urandom; c = gen_check(d); c[2] = ~c[2];
        i_ready = 1'b0; i_valid = 1'b1; i_data = d; i_check = c; i_addr = 32'h400;
        tick();
        i_valid = 1'b0;
        for (int t = 0; t < 4 && !a_valid; t++) tick();
        i_ready = 1'b1; i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        n_vec++;
        if (!fired || got !== want) begin
            n_err++; $display("FAIL clr_word: fired %0b got %h want %h", fired, got, want);
        end
        n_vec++;
        if ({a_sec_cnt, b_sec_cnt, a_ded_cnt, a_log_valid, a_log_ded, a_log_addr} !== {16'd1, 2'd1, 16'd0, 1'b1, 1'b0, 32'h400}) begin
            n_err++; $display("FAIL clr_coincident: got %h want %h", {a_sec_cnt, b_sec_cnt, a_ded_cnt, a_log_valid, a_log_ded, a_log_addr},
                {16'd1, 2'd1, 16'd0, 1'b1, 1'b0, 32'h400});
        end
        $display("clear with event: sec_cnt=%0d log_addr=%h", a_sec_cnt, a_log_addr);
    endtask

    task automatic test_reset_mid();
        logic [117:0] ra;
        logic [89:0]  rb;
        logic [31:0]  d;
        bit ok;
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            i_valid = 1'b1; i_data = d; i_check = gen_check(d) ^ 8'h01; i_addr = 32'h600 + 32'(k);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_clear();
        ra = {a_ready, a_valid, a_data, a_check, a_syn, a_sec, a_ded, a_sec_cnt, a_ded_cnt, a_log_valid, a_log_ded, a_log_addr};
        rb = {b_ready, b_valid, b_data, b_check, b_syn, b_sec, b_ded, b_sec_cnt, b_ded_cnt, b_log_valid, b_log_ded, b_log_addr};
        n_vec++;
        if (ra !== {1'b1, 117'd0}) begin
            n_err++; $display("FAIL midstream_reset: got %h want %h", ra, {1'b1, 117'd0});
        end
        n_vec++;
        if (rb !== {1'b1, 89'd0}) begin
            n_err++; $display("FAIL midstream_reset_sat: got %h want %h", rb, {1'b1, 89'd0});
        end
        i_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        d = $urandom;
        send_word(d, gen_check(d), 32'h700, ok);
        n_vec++;
        if (!ok || got !== want || exp_q.size() != 0) begin
            n_err++; $display("FAIL after_reset_word: got %h want %h", got, want);
        end
        $display("midstream reset: pipeline flushed, next word data=%h", got[49:18]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_stall();
        test_random();
        test_saturate_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
